// File: rtl/snake_pkg.sv
// Shared snake types, sizing defaults and grid position helpers.
package snake_pkg;

    localparam int MAX_LEN         = 16;
    localparam int NUM_LEN         = 10;
    localparam int MAX_LEN_BIT_LEN = 4;
    localparam int COORD           = NUM_LEN / 2;

    typedef logic [1:0]       dir_t;
    typedef logic [NUM_LEN-1:0] pos_t;
    typedef logic [COORD-1:0] coord_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    function automatic pos_t pack_pos(input coord_t x, input coord_t y);
        return {y, x};
    endfunction

    function automatic coord_t pos_x(input pos_t p);
        return p[COORD-1:0];
    endfunction

    function automatic coord_t pos_y(input pos_t p);
        return p[NUM_LEN-1:COORD];
    endfunction

    // Reversing a direction flips bit 1 (up<->down, right<->left).
    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b10;
    endfunction

    // One cell in direction d, wrapping at the playfield edges.
    function automatic pos_t next_pos(input pos_t p, input dir_t d,
                                      input int grid_w, input int grid_h);
        coord_t x;
        coord_t y;
        x = pos_x(p);
        y = pos_y(p);
        case (d)
            DIR_UP:    y = (y == '0) ? coord_t'(grid_h - 1) : y - coord_t'(1);
            DIR_DOWN:  y = (y == coord_t'(grid_h - 1)) ? '0 : y + coord_t'(1);
            DIR_LEFT:  x = (x == '0) ? coord_t'(grid_w - 1) : x - coord_t'(1);
            default:   x = (x == coord_t'(grid_w - 1)) ? '0 : x + coord_t'(1);
        endcase
        return pack_pos(x, y);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Game-step divider: counts 0..STEP_CYCLES-1 while enabled, held at 0 otherwise.
module step_timer #(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CW-1:0] count;

    assign tick = en && (count == CW'(STEP_CYCLES - 1));

    // Free-running step counter, wraps on tick and clears when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// One player's snake: body shift register, length, direction latch and run state.
// Handshake: none of the inputs are acknowledged; dir_valid qualifies dir_in for one
// cycle, grow is a one-cycle pulse, start and should_stop are levels sampled each clk.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN         = snake_pkg::MAX_LEN,
    parameter int NUM_LEN         = snake_pkg::NUM_LEN,
    parameter int MAX_LEN_BIT_LEN = snake_pkg::MAX_LEN_BIT_LEN,
    parameter int GRID_W          = 32,
    parameter int GRID_H          = 24,
    parameter int INIT_X          = 8,
    parameter int INIT_Y          = 12,
    parameter int INIT_DIR        = 1,
    parameter int INIT_LEN        = 3,
    parameter int STEP_CYCLES     = 25_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   dir_in,
    input  logic                         dir_valid,
    input  logic                         grow,
    input  logic                         should_stop,
    output logic [MAX_LEN*NUM_LEN-1:0]   snake,
    output logic [MAX_LEN_BIT_LEN-1:0]   len,
    output logic                         alive,
    output logic                         step_done,
    output state_t                       state_dbg
);

    localparam logic [MAX_LEN_BIT_LEN-1:0] LEN_MAX   = MAX_LEN_BIT_LEN'(MAX_LEN - 1);
    localparam logic [MAX_LEN_BIT_LEN-1:0] LEN_RESET = MAX_LEN_BIT_LEN'(INIT_LEN);
    localparam dir_t                       DIR_RESET = dir_t'(INIT_DIR);

    // Reset body: a straight line trailing away from the initial heading, every slot filled.
    function automatic logic [MAX_LEN*NUM_LEN-1:0] init_body();
        logic [MAX_LEN*NUM_LEN-1:0] b;
        pos_t                       p;
        b = '0;
        p = pack_pos(coord_t'(INIT_X), coord_t'(INIT_Y));
        for (int i = 0; i < MAX_LEN; i++) begin
            b[i*NUM_LEN +: NUM_LEN] = p;
            p = next_pos(p, opposite(DIR_RESET), GRID_W, GRID_H);
        end
        return b;
    endfunction

    localparam logic [MAX_LEN*NUM_LEN-1:0] INIT_BODY = init_body();

    state_t state;
    dir_t   last_dir;
    dir_t   pend_dir;
    logic   grow_pend;
    logic   tick;
    logic   step;
    dir_t   ref_dir;
    pos_t   next_head;

    assign state_dbg = state;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_RUN),
        .tick(tick)
    );

    // A stop request wins over a step landing in the same cycle.
    assign step      = tick && (state == ST_RUN) && !should_stop;
    assign next_head = next_pos(snake[NUM_LEN-1:0], pend_dir, GRID_W, GRID_H);
    // In a step cycle pend_dir becomes the direction moved, so a new request is
    // checked against it; this keeps a same-cycle request from reversing the snake.
    assign ref_dir   = step ? pend_dir : last_dir;

    // Run-state FSM plus body, length, direction and growth bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            snake     <= INIT_BODY;
            len       <= LEN_RESET;
            last_dir  <= DIR_RESET;
            pend_dir  <= DIR_RESET;
            grow_pend <= 1'b0;
            alive     <= 1'b1;
            step_done <= 1'b0;
        end else begin
            step_done <= step;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (should_stop) begin
                        state <= ST_DEAD;
                        alive <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_DEAD;
                    alive <= 1'b0;
                end
            endcase

            if (state != ST_DEAD) begin
                if (dir_valid && (dir_in != opposite(ref_dir))) begin
                    pend_dir <= dir_in;
                end

                if (step) begin
                    // A grow arriving in the step cycle still counts for this step.
                    if ((grow_pend || grow) && (len < LEN_MAX)) begin
                        len <= len + MAX_LEN_BIT_LEN'(1);
                    end
                    grow_pend <= 1'b0;
                    snake     <= {snake[(MAX_LEN-1)*NUM_LEN-1:0], next_head};
                    last_dir  <= pend_dir;
                end else if (grow) begin
                    grow_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine with a short game step.
module tb_snake_body_engine;
    import snake_pkg::*;

    localparam int ML = 16;
    localparam int NL = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [1:0] dir_in;
    logic dir_valid;
    logic grow;
    logic should_stop;
    logic [ML*NL-1:0] snake;
    logic [3:0] len;
    logic alive;
    logic step_done;
    state_t state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    snake_body_engine #(
        .GRID_W(32),
        .GRID_H(24),
        .STEP_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir_in     (dir_in),
        .dir_valid  (dir_valid),
        .grow       (grow),
        .should_stop(should_stop),
        .snake      (snake),
        .len        (len),
        .alive      (alive),
        .step_done  (step_done),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] seg(input int i);
        return 32'(snake[i*NL +: NL]);
    endfunction

    function automatic logic [31:0] p(input int x, input int y);
        return 32'(y * 32 + x);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_step();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!step_done && t < 50);
        if (!step_done) check("step_timeout", 32'(step_done), 32'd1);
    endtask

    task automatic pulse_dir(input logic [1:0] d);
        dir_in    = d;
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        @(negedge clk);
        grow = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int sd_cnt;
    int t1, t2, t3;
    int exp_len;

    initial begin
        rst = 1'b1; start = 1'b0; dir_in = 2'd0; dir_valid = 1'b0;
        grow = 1'b0; should_stop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing moves without start.
        sd_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (step_done) sd_cnt++;
        end
        check("idle_state", 32'(state_dbg), 32'(ST_IDLE));
        check("idle_head", seg(0), p(8, 12));
        check("idle_seg1", seg(1), p(7, 12));
        check("idle_seg2", seg(2), p(6, 12));
        check("idle_seg3", seg(3), p(5, 12));
        check("idle_len", 32'(len), 32'd3);
        check("idle_alive", 32'(alive), 32'd1);
        check("idle_no_step", 32'(sd_cnt), 32'd0);

        // Three plain steps to the right.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_step(); t1 = cyc;
        wait_step(); t2 = cyc;
        wait_step(); t3 = cyc;
        check("period_a", 32'(t2 - t1), 32'd4);
        check("period_b", 32'(t3 - t2), 32'd4);
        check("run_head", seg(0), p(11, 12));
        check("run_seg1", seg(1), p(10, 12));
        check("run_seg2", seg(2), p(9, 12));
        check("run_len", 32'(len), 32'd3);

        // Travel to (31,5) heading right.
        pulse_dir(DIR_UP);
        repeat (7) wait_step();
        check("up7_head", seg(0), p(11, 5));
        pulse_dir(DIR_RIGHT);
        repeat (20) wait_step();
        check("right20_head", seg(0), p(31, 5));
        check("right20_seg1", seg(1), p(30, 5));

        // Up accepted, following left rejected as reversal of right.
        pulse_dir(DIR_UP);
        pulse_dir(DIR_LEFT);
        wait_step();
        check("turn_head", seg(0), p(31, 4));
        check("turn_seg1", seg(1), p(31, 5));
        repeat (4) wait_step();
        check("top_head", seg(0), p(31, 0));
        wait_step();
        check("wrap_y_head", seg(0), p(31, 23));

        // Grow landing in the tick cycle counts for that step.
        repeat (3) @(negedge clk);
        grow = 1'b1;
        @(negedge clk);
        grow = 1'b0;
        check("grow_tick_step", 32'(step_done), 32'd1);
        check("grow_tick_len", 32'(len), 32'd4);
        check("grow_tick_head", seg(0), p(31, 22));

        // 13 more grows: length saturates at 15, body keeps shifting.
        exp_len = 4;
        for (int i = 0; i < 13; i++) begin
            pulse_grow();
            wait_step();
            exp_len = (exp_len < 15) ? exp_len + 1 : 15;
            check($sformatf("grow_len_%0d", i), 32'(len), 32'(exp_len));
        end
        check("sat_len", 32'(len), 32'd15);
        check("sat_head", seg(0), p(31, 9));
        check("sat_seg1", seg(1), p(31, 10));
        check("sat_seg14", seg(14), p(31, 23));

        // Stop coinciding with a tick: no move, snake dies.
        repeat (3) @(negedge clk);
        should_stop = 1'b1;
        @(negedge clk);
        check("stop_no_step", 32'(step_done), 32'd0);
        check("stop_alive", 32'(alive), 32'd0);
        check("stop_state", 32'(state_dbg), 32'(ST_DEAD));
        check("stop_head", seg(0), p(31, 9));
        sd_cnt = 0;
        dir_in = DIR_LEFT; dir_valid = 1'b1; grow = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (step_done) sd_cnt++;
        end
        dir_valid = 1'b0; grow = 1'b0;
        check("dead_no_step", 32'(sd_cnt), 32'd0);
        check("dead_head", seg(0), p(31, 9));
        check("dead_seg1", seg(1), p(31, 10));
        check("dead_len", 32'(len), 32'd15);

        // Restart, move once, then reset mid-step.
        rst = 1'b1;
        @(negedge clk);
        should_stop = 1'b0;
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulse_dir(DIR_DOWN);
        pulse_grow();
        wait_step();
        check("rs_move_head", seg(0), p(8, 13));
        check("rs_move_len", 32'(len), 32'd4);
        pulse_dir(DIR_LEFT);
        pulse_grow();
        #2 rst = 1'b1;
        #1;
        check("async_rst_head", seg(0), p(8, 12));
        check("async_rst_seg1", seg(1), p(7, 12));
        check("async_rst_len", 32'(len), 32'd3);
        check("async_rst_alive", 32'(alive), 32'd1);
        check("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("async_rst_sd", 32'(step_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_step();
        check("post_rst_head", seg(0), p(9, 12));
        check("post_rst_len", 32'(len), 32'd3);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
